// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (ifetch/data) arbiter onto a single fixed-latency memory.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; fixed data priority otherwise.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ABITS = 30
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             I_REQ,
  input  logic [ABITS-1:0] I_ADDR,
  output logic             I_ACK,
  output logic [31:0]      I_RDATA,
  input  logic             D_REQ,
  input  logic             D_WE,
  input  logic [3:0]       D_BE,
  input  logic [ABITS-1:0] D_ADDR,
  input  logic [31:0]      D_WDATA,
  output logic             D_ACK,
  output logic [31:0]      D_RDATA,
  input  logic             INHIBIT,
  output logic [ABITS-1:0] M_ADDR,
  output logic [31:0]      M_WD,
  output logic [3:0]       M_BE,
  output logic             M_RE,
  output logic             M_WE,
  input  logic [31:0]      M_RDATA,
  output logic             BUSY,
  output logic             OWNER_D
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic pick_d;
`ifdef MEM_ARBITER_RR_EN
  // Reset to "data served last" so ifetch wins the first contested grant.
  logic rr_last_d;
  assign pick_d = D_REQ & (~I_REQ | ~rr_last_d);
`else
  assign pick_d = D_REQ;
`endif
  assign BUSY = state != IDLE;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      cnt     <= '0;
      OWNER_D <= 1'b0;
      I_ACK   <= 1'b0;
      D_ACK   <= 1'b0;
      I_RDATA <= '0;
      D_RDATA <= '0;
      M_ADDR  <= '0;
      M_WD    <= '0;
      M_BE    <= '0;
      M_RE    <= 1'b0;
      M_WE    <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      rr_last_d <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (!INHIBIT && (I_REQ || D_REQ)) begin
          state   <= ACCESS;
          cnt     <= 4'(WAIT_CYCLES - 1);
          OWNER_D <= pick_d;
          M_ADDR  <= pick_d ? D_ADDR : I_ADDR;
          M_BE    <= pick_d ? D_BE : 4'hF;
          M_RE    <= ~(pick_d & D_WE);
          M_WE    <= pick_d & D_WE;
          if (pick_d) M_WD <= D_WDATA;
`ifdef MEM_ARBITER_RR_EN
          rr_last_d <= pick_d;
`endif
        end
        ACCESS: if (cnt == 4'd0) begin
          state <= DONE;
          M_RE  <= 1'b0;
          M_WE  <= 1'b0;
          I_ACK <= ~OWNER_D;
          D_ACK <= OWNER_D;
          // M_RE is still high on the last cycle only for reads
          if (M_RE && OWNER_D) D_RDATA <= M_RDATA;
          if (M_RE && !OWNER_D) I_RDATA <= M_RDATA;
        end else begin
          cnt <= cnt - 4'd1;
        end
        DONE: begin
          state <= IDLE;
          I_ACK <= 1'b0;
          D_ACK <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, memory access length in cycles (legal 1..15).
REQ-002 SHALL have parameter ABITS, default 30, word-address width.
REQ-003 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
  CLK      in   1      clock, all state on rising edge
  RESET_N  in   1      asynchronous active-low reset
  I_REQ    in   1      ifetch read request, held until I_ACK
  I_ADDR   in   ABITS  ifetch word address
  I_ACK    out  1      one-cycle ifetch completion pulse
  I_RDATA  out  32     ifetch read data, registered
  D_REQ    in   1      data request, held until D_ACK
  D_WE     in   1      1 = write, 0 = read
  D_BE     in   4      data byte enables
  D_ADDR   in   ABITS  data word address
  D_WDATA  in   32     data write data
  D_ACK    out  1      one-cycle data completion pulse
  D_RDATA  out  32     data read data, registered
  INHIBIT  in   1      blocks new grants
  M_ADDR   out  ABITS  memory address
  M_WD     out  32     memory write data
  M_BE     out  4      memory byte enables
  M_RE     out  1      memory read strobe
  M_WE     out  1      memory write strobe
  M_RDATA  in   32     memory read data, valid on last access cycle
  BUSY     out  1      state != IDLE
  OWNER_D  out  1      current/last grant: 1 = data, 0 = ifetch

Function
REQ-004 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; no other transitions.
REQ-005 IDLE: if INHIBIT=0 and any REQ=1, SHALL grant one requester, load wait counter with WAIT_CYCLES-1, go ACCESS; otherwise stay IDLE.
REQ-006 Grant SHALL latch address, BE, WD and WE of the winner into registers; M_* driven only from these registers.
REQ-007 ACCESS: M_RE=~WE or M_WE=WE held for exactly WAIT_CYCLES cycles; M_ADDR/M_BE/M_WD stable throughout; ifetch access SHALL force M_BE=4'hF, M_WE=0.
REQ-008 Last ACCESS cycle (counter=0): SHALL capture M_RDATA into owner's RDATA register on reads, go DONE; writes leave RDATA unchanged.
REQ-009 DONE: owner's ACK=1 for exactly one cycle, then IDLE; ACK never asserted in other states.
REQ-010 Latency: REQ seen in IDLE at cycle N -> ACK at cycle N+WAIT_CYCLES+1; minimum request spacing WAIT_CYCLES+2.
REQ-011 Fixed priority (default): D_REQ wins over I_REQ when both asserted.
REQ-012 REQ dropped mid-access SHALL NOT abort: access completes, ACK still pulsed.
REQ-013 INHIBIT SHALL affect only IDLE grant decision; in-flight access completes.
REQ-014 In IDLE/DONE, M_RE=M_WE=0; M_ADDR/M_BE/M_WD hold last values.
REQ-015 I_RDATA/D_RDATA SHALL hold value until the next read completion for that port.

Reset
REQ-016 RESET_N=0 SHALL immediately force IDLE, counter 0, OWNER_D=0, all outputs 0 (ACKs, strobes, RDATA, M_ADDR, M_WD, M_BE, BUSY).
REQ-017 Reset mid-access SHALL abort it with no ACK; first grant possible on first edge after RESET_N rises.

Configuration
REQ-018 Macro MEM_ARBITER_RR_EN defined: SHALL use round-robin on simultaneous requests -- requester not served by last grant (OWNER_D) wins; after reset ifetch served first.
REQ-019 MEM_ARBITER_RR_EN undefined: SHALL use fixed priority per REQ-011; RR logic absent.

Verification
REQ-020 WAIT_CYCLES=2, I_REQ=1 at cycle 0, I_ADDR=0x100, M_RDATA=0xDEADBEEF on cycle 2 -> M_RE cycles 1-2, I_ACK cycle 3, I_RDATA=0xDEADBEEF.
REQ-021 D_REQ write D_ADDR=0x40, D_BE=4'b0011, D_WDATA=0x12345678 -> M_WE=1 two cycles with those values, M_RE=0, D_ACK once, D_RDATA unchanged.
REQ-022 I_REQ and D_REQ both held continuously 4 accesses -> fixed: D,D,D,D; RR build: I,D,I,D; ACK spacing 4 cycles.
REQ-023 INHIBIT=1 with D_REQ=1 for 5 cycles then INHIBIT=0 -> no strobe while inhibited, grant next cycle, D_ACK 3 cycles later.
REQ-024 RESET_N low on second ACCESS cycle -> strobes/BUSY/ACK to 0 at once, no ACK; held D_REQ after release -> fresh full access.
REQ-025 D_REQ dropped after grant cycle -> access finishes, D_ACK pulsed, FSM returns IDLE.
